// File: rtl/ap_ctrl_status_recorder_if.sv
// Record stream between the recorder (master) and its consumer (slave).
// The head record is held stable while rec_valid=1 and rec_ready=0.
interface ap_ctrl_status_recorder_if #(
    parameter int unsigned CNT_W = 32
);
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_latency;
    logic [CNT_W-1:0] rec_interval;
    logic [CNT_W-1:0] rec_index;
    logic [1:0]       rec_flags;

    modport master (
        output rec_valid,
        output rec_latency,
        output rec_interval,
        output rec_index,
        output rec_flags,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_latency,
        input  rec_interval,
        input  rec_index,
        input  rec_flags,
        output rec_ready
    );
endinterface

// File: rtl/ap_ctrl_status_recorder.sv
// Observes an ap_ctrl_hs / ap_ctrl_chain handshake and records per-transaction
// latency, start-to-start interval and sequence index into a small FIFO.
// On finish, one final record (incomplete transaction or sentinel, flagged
// "last") is always queued before flush_done rises.
// DEPTH must be a power of two and at least 2.
module ap_ctrl_status_recorder #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ap_start,
    input  logic                      ap_done,
    input  logic                      ap_continue,
    input  logic                      finish,
    ap_ctrl_status_recorder_if.master rec,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      busy,
    output logic                      flush_done
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HOLD,
        S_FLUSH,
        S_END
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] lat;
        logic [CNT_W-1:0] iv;
        logic [CNT_W-1:0] idx;
        logic [1:0]       flags;
    } rec_t;

    // cyc only ever grows, so the guard never fires in practice; it keeps the
    // difference from wrapping should a captured value ever exceed cyc.
    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] t_start_q, t_start_d;
    logic [CNT_W-1:0] prev_start_q, prev_start_d;
    logic             prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0] iv_q, iv_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pend_lat_q, pend_lat_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             flush_done_q, flush_done_d;

    rec_t             mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q, count_d;

    // Push request from the FSM
    logic             push_norm;
    logic             push_final;
    rec_t             push_rec;

    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_space;
    logic             fifo_wr;
    logic             rec_drop;
    logic [CNT_W-1:0] iv_now;
    logic [CNT_W-1:0] run_lat;

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_pop   = (count_q != '0) && rec.rec_ready;
    // A full FIFO still takes a push in the same cycle as a pop.
    assign fifo_space = !fifo_full || fifo_pop;
    assign fifo_wr    = (push_norm || push_final) && fifo_space;
    assign rec_drop   = push_norm && !fifo_space;

    assign iv_now  = prev_vld_q ? sat_sub(cyc_q, prev_start_q) : '0;
    assign run_lat = sat_sub(cyc_q, t_start_q);

    // FSM next state, transaction bookkeeping and record construction
    always_comb begin
        state_d      = state_q;
        t_start_d    = t_start_q;
        prev_start_d = prev_start_q;
        prev_vld_d   = prev_vld_q;
        iv_d         = iv_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_lat_d   = pend_lat_q;
        flush_done_d = flush_done_q;
        push_norm    = 1'b0;
        push_final   = 1'b0;
        push_rec     = '{lat: '0, iv: '0, idx: idx_q, flags: 2'b00};

        unique case (state_q)
            S_IDLE: begin
                if (finish) begin
                    state_d = S_FLUSH;
                end else if (ap_start) begin
                    prev_start_d = cyc_q;
                    prev_vld_d   = 1'b1;
                    if (ap_done) begin
                        // Zero-latency transaction: record now, remain idle.
                        push_norm   = 1'b1;
                        push_rec.iv = iv_now;
                    end else begin
                        t_start_d = cyc_q;
                        iv_d      = iv_now;
                        state_d   = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (finish) begin
                    pend_d     = 1'b1;
                    pend_lat_d = run_lat;
                    state_d    = S_FLUSH;
                end else if (ap_done) begin
                    push_norm    = 1'b1;
                    push_rec.lat = run_lat;
                    push_rec.iv  = iv_q;
                    state_d      = ap_continue ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (finish) begin
                    state_d = S_FLUSH;
                end else if (ap_continue) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                push_final     = 1'b1;
                push_rec.flags = {1'b1, pend_q};
                if (pend_q) begin
                    push_rec.lat = pend_lat_q;
                    push_rec.iv  = iv_q;
                end
                if (fifo_space) begin
                    flush_done_d = 1'b1;
                    state_d      = S_END;
                end
            end
            S_END: begin
                state_d = S_END;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_norm) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // FIFO occupancy next value
    always_comb begin
        count_d = count_q;
        unique case ({fifo_wr, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Saturating drop counter next value
    always_comb begin
        drop_d = drop_q;
        if (rec_drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // State register and control/bookkeeping registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            t_start_q    <= '0;
            prev_start_q <= '0;
            prev_vld_q   <= 1'b0;
            iv_q         <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_lat_q   <= '0;
            drop_q       <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= (cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
            t_start_q    <= t_start_d;
            prev_start_q <= prev_start_d;
            prev_vld_q   <= prev_vld_d;
            iv_q         <= iv_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_lat_q   <= pend_lat_d;
            drop_q       <= drop_d;
            flush_done_q <= flush_done_d;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are only visible through the valid-gated head
    always_ff @(posedge clock) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    // Head record outputs are forced to zero when the FIFO is empty
    assign rec.rec_valid    = (count_q != '0);
    assign rec.rec_latency  = rec.rec_valid ? mem_q[rd_ptr_q].lat   : '0;
    assign rec.rec_interval = rec.rec_valid ? mem_q[rd_ptr_q].iv    : '0;
    assign rec.rec_index    = rec.rec_valid ? mem_q[rd_ptr_q].idx   : '0;
    assign rec.rec_flags    = rec.rec_valid ? mem_q[rd_ptr_q].flags : '0;

    assign drop_cnt   = drop_q;
    assign busy       = (state_q == S_ACTIVE);
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_ap_ctrl_status_recorder.sv
// Self-checking bench: directed scenarios plus randomized handshake traffic,
// compared every cycle against a transaction-level reference model.
module tb_ap_ctrl_status_recorder;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ap_start = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_continue = 1'b1;
    logic             finish = 1'b0;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;
    logic             flush_done;

    ap_ctrl_status_recorder_if #(.CNT_W(CNT_W)) rif ();

    ap_ctrl_status_recorder #(
        .CNT_W(CNT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_continue(ap_continue),
        .finish     (finish),
        .rec        (rif),
        .drop_cnt   (drop_cnt),
        .busy       (busy),
        .flush_done (flush_done)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        bit [31:0] lat;
        bit [31:0] iv;
        bit [31:0] idx;
        bit [1:0]  fl;
    } rec_t;

    rec_t      m_q[$];
    rec_t      m_final;
    bit [31:0] m_cyc, m_tstart, m_prev, m_iv, m_index, m_drop;
    bit        m_have_prev, m_inflight, m_waiting_continue, m_flushing, m_flushed;

    task automatic m_reset();
        m_q.delete();
        m_cyc = 0; m_tstart = 0; m_prev = 0; m_iv = 0; m_index = 0; m_drop = 0;
        m_have_prev = 0; m_inflight = 0; m_waiting_continue = 0;
        m_flushing = 0; m_flushed = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic m_edge();
        bit   pop;
        bit   room;
        bit   have_new;
        rec_t r;
        pop      = (m_q.size() != 0) && rif.rec_ready;
        room     = (m_q.size() < DEPTH) || pop;
        have_new = 0;
        if (pop) void'(m_q.pop_front());
        if (m_flushed) begin
            // only draining after the final record
        end else if (m_flushing) begin
            if (room) begin
                m_q.push_back(m_final);
                m_flushed = 1;
            end
        end else if (finish) begin
            if (m_inflight) m_final = '{m_cyc - m_tstart, m_iv, m_index, 2'b11};
            else            m_final = '{0, 0, m_index, 2'b10};
            m_flushing = 1;
            m_inflight = 0;
            m_waiting_continue = 0;
        end else if (m_waiting_continue) begin
            if (ap_continue) m_waiting_continue = 0;
        end else if (m_inflight) begin
            if (ap_done) begin
                r = '{m_cyc - m_tstart, m_iv, m_index, 2'b00};
                have_new = 1;
                m_inflight = 0;
                m_waiting_continue = !ap_continue;
            end
        end else if (ap_start) begin
            bit [31:0] iv;
            iv = m_have_prev ? m_cyc - m_prev : 0;
            m_prev = m_cyc;
            m_have_prev = 1;
            if (ap_done) begin
                r = '{0, iv, m_index, 2'b00};
                have_new = 1;
            end else begin
                m_inflight = 1;
                m_tstart = m_cyc;
                m_iv = iv;
            end
        end
        if (have_new) begin
            if (room) m_q.push_back(r);
            else if (m_drop != '1) m_drop++;
            m_index++;
        end
        if (m_cyc != '1) m_cyc++;
    endtask

    task automatic compare_all();
        check("rec_valid", rif.rec_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("rec_latency", rif.rec_latency, m_q[0].lat);
            check("rec_interval", rif.rec_interval, m_q[0].iv);
            check("rec_index", rif.rec_index, m_q[0].idx);
            check("rec_flags", rif.rec_flags, m_q[0].fl);
        end
        check("drop_cnt", drop_cnt, m_drop);
        check("busy", busy, m_inflight);
        check("flush_done", flush_done, m_flushed);
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) m_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ap_start = 0; ap_done = 0; ap_continue = 1; finish = 0; rif.rec_ready = 0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    task automatic idle_to(input bit [31:0] target);
        ap_start = 0; ap_done = 0;
        for (int i = 0; i < 200 && m_cyc != target; i++) step();
    endtask

    task automatic pulse_start();
        ap_start = 1; step(); ap_start = 0;
    endtask

    task automatic pulse_done();
        ap_done = 1; step(); ap_done = 0;
    endtask

    initial begin
        rif.rec_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", rif.rec_valid, 1'b0);
        check("rst_drop", drop_cnt, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);

        // Single transaction: start at 5, done at 12
        rif.rec_ready = 1;
        idle_to(5);
        pulse_start();
        check("busy_active", busy, 1'b1);
        idle_to(12);
        pulse_done();
        check("t1_lat", rif.rec_latency, 7);
        check("t1_iv", rif.rec_interval, 0);
        check("t1_idx", rif.rec_index, 0);
        check("t1_flags", rif.rec_flags, 2'b00);

        // Starts at 10 and 30, 3-cycle latency each
        do_reset();
        rif.rec_ready = 1;
        idle_to(10); pulse_start();
        idle_to(13); pulse_done();
        idle_to(30); pulse_start();
        idle_to(33); pulse_done();
        check("t2_lat", rif.rec_latency, 3);
        check("t2_iv", rif.rec_interval, 20);
        check("t2_idx", rif.rec_index, 1);

        // Overflow: 10 transactions with no consumer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pulse_start(); step(); pulse_done();
        end
        check("ovf_drop", drop_cnt, 2);
        rif.rec_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_idx", rif.rec_index, i);
            step();
        end
        check("ovf_empty", rif.rec_valid, 1'b0);

        // Hold: continue low at done, start during hold is ignored
        do_reset();
        rif.rec_ready = 1;
        pulse_start(); step();
        ap_continue = 0; pulse_done();
        for (int i = 0; i < 4; i++) begin
            ap_start = (i == 1);
            step();
            check("hold_busy", busy, 1'b0);
        end
        ap_start = 0;
        ap_continue = 1; step();
        check("hold_exit_busy", busy, 1'b0);
        pulse_start(); pulse_done();
        check("hold_next_idx", rif.rec_index, 1);

        // Finish with full FIFO during an active transaction
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pulse_start(); pulse_done();
        end
        pulse_start();
        step(); step(); step();
        finish = 1; step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_wait", flush_done, 1'b0);
        end
        rif.rec_ready = 1; step();
        check("flush_done_set", flush_done, 1'b1);
        for (int i = 0; i < 7; i++) begin
            ap_start = 1'($urandom); ap_done = 1'($urandom);
            step();
        end
        check("final_lat", rif.rec_latency, 4);
        check("final_flags", rif.rec_flags, 2'b11);
        check("final_idx", rif.rec_index, 8);
        step();
        check("final_empty", rif.rec_valid, 1'b0);
        ap_start = 0; ap_done = 0; finish = 0;

        // Reset during an active transaction with queued records
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_start(); pulse_done();
        end
        pulse_start();
        check("pre_rst_busy", busy, 1'b1);
        reset = 0;
        #1;
        m_reset();
        check("mid_rst_valid", rif.rec_valid, 1'b0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_busy", busy, 1'b0);
        step(); step();
        reset = 1;
        rif.rec_ready = 1;
        pulse_start(); pulse_done();
        check("post_rst_idx", rif.rec_index, 0);

        // Randomized traffic against the model
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                ap_start      = ($urandom_range(0, 99) < 30);
                ap_done       = ($urandom_range(0, 99) < 30);
                ap_continue   = ($urandom_range(0, 99) < 70);
                rif.rec_ready = ($urandom_range(0, 99) < (round == 1 ? 10 : 40));
                finish        = ($urandom_range(0, 199) == 0) || finish;
                step();
            end
        end
        finish = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
